// File: rtl/addsub_pkg.sv
// addsub_pkg: shared FSM state, op encodings and slice-count helper for the serial add/sub unit
package addsub_pkg;
   typedef enum logic [1:0] {IDLE, RUN, NEG, DONE} state_t;
   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;
   function automatic int slices(input int n, input int d);
      return n / d;
   endfunction
endpackage

// File: rtl/digit_adder.sv
// digit_adder: D-bit ripple adder built from full_adder_1bit cells
module digit_adder #(
   parameter int D = 1
) (
   input  logic [D-1:0] x,
   input  logic [D-1:0] y,
   input  logic         cin,
   output logic [D-1:0] s,
   output logic         cout
);
   logic [D:0] c;
   assign c[0] = cin;
   for (genvar i = 0; i < D; i++) begin : g_fa
      full_adder_1bit u_fa (.a(x[i]), .b(y[i]), .cin(c[i]), .s(s[i]), .cout(c[i+1]));
   end
   assign cout = c[D];
endmodule

// File: rtl/full_adder_1bit.sv
// full_adder_1bit: single-bit full adder cell
module full_adder_1bit (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_addsub_unit.sv
// serial_addsub_unit: digit-serial unsigned add/sub, LSB slice first, sign-magnitude subtract result
module serial_addsub_unit
   import addsub_pkg::*;
#(
   parameter int N = 8,
   parameter int D = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         op,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] res,
   output logic         negout,
   output logic         carry_out,
   output logic         zero
);
   localparam int S = slices(N, D);
   localparam int CW = $clog2(S + 1);
   if (N % D != 0) begin : g_bad_digit
      $error("serial_addsub_unit: N must be a multiple of D");
   end
   state_t st;
   logic [N-1:0] sa, sb, r, r_nx;
   logic [CW-1:0] cnt;
   logic [D-1:0] x, y, s;
   logic carry, fc, op_q, cout, last, to_neg, fin, go_done;
   // NEG reuses the adder to form ~r + 1 one slice at a time
   assign x = st == NEG ? ~r[D-1:0] : sa[D-1:0];
   assign y = st == NEG ? '0 : sb[D-1:0];
   digit_adder #(.D(D)) u_dig (.x(x), .y(y), .cin(carry), .s(s), .cout(cout));
   assign r_nx = (r >> D) | (N'(s) << (N - D));
   assign last = cnt == CW'(S - 1);
   assign to_neg = op_q == OP_SUB && !cout;
   assign fin = st == RUN ? cout : fc;
   assign go_done = last && (st == NEG || (st == RUN && !to_neg));
   assign busy = st != IDLE;
   assign done = st == DONE;
   always_ff @(posedge clk) begin
      if (rst) begin
         st <= IDLE;
         sa <= '0;
         sb <= '0;
         r <= '0;
         cnt <= '0;
         carry <= 1'b0;
         fc <= 1'b0;
         op_q <= 1'b0;
         res <= '0;
         negout <= 1'b0;
         carry_out <= 1'b0;
         zero <= 1'b0;
      end else begin
         unique case (st)
            IDLE: if (start) begin
               sa <= a;
               sb <= op == OP_ADD ? b : ~b;
               op_q <= op;
               carry <= op;
               cnt <= '0;
               st <= RUN;
            end
            RUN: begin
               sa <= sa >> D;
               sb <= sb >> D;
               r <= r_nx;
               cnt <= last ? '0 : cnt + CW'(1);
               carry <= (last && to_neg) ? 1'b1 : cout;
               if (last) begin
                  fc <= cout;
                  st <= to_neg ? NEG : DONE;
               end
            end
            NEG: begin
               r <= r_nx;
               carry <= cout;
               cnt <= last ? '0 : cnt + CW'(1);
               if (last) st <= DONE;
            end
            DONE: st <= IDLE;
            default: st <= IDLE;
         endcase
         if (go_done) begin
            res <= r_nx;
            zero <= ~|r_nx;
            carry_out <= fin;
            negout <= op_q == OP_SUB && !fin;
         end
      end
   end
endmodule
